// File: rtl/apb_req_master.sv
// APB initiator: turns one outstanding valid/ready request into an APB SETUP/ACCESS
// transfer and returns read data / error status on a valid/ready response channel.
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  // Handshakes: a beat transfers on the clock edge where valid & ready are both 1;
  // valid never waits on ready, and rsp_* hold stable while rsp_valid_o & !rsp_ready_i.
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic                      req_write_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic [1:0]                dbg_state
);

  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_d;
  logic [31:0]               pwdata_d;
  logic                      pwrite_d;
  logic                      psel_d;
  logic                      penable_d;
  logic                      rsp_valid_d;
  logic [31:0]               rsp_rdata_d;
  logic                      rsp_err_d;
  logic                      rsp_timeout_d;
  logic [CNT_W-1:0]          wdog_q, wdog_d;

  assign req_ready_o = (state_q == IDLE);
  assign dbg_state   = state_q;

  always_comb begin
    state_d       = state_q;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    pwrite_d      = PWRITE;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    rsp_valid_d   = rsp_valid_o;
    rsp_rdata_d   = rsp_rdata_o;
    rsp_err_d     = rsp_err_o;
    rsp_timeout_d = rsp_timeout_o;
    wdog_d        = wdog_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          paddr_d   = req_addr_i;
          pwdata_d  = req_wdata_i;
          pwrite_d  = req_write_i;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A completing slave takes priority over the watchdog firing in the same cycle.
        if (PREADY) begin
          rsp_rdata_d   = (PWRITE || PSLVERR) ? 32'h0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          wdog_d        = '0;
          state_d       = RESP;
        end else if (WDOG_EN && (wdog_q == CNT_LAST)) begin
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          wdog_d        = '0;
          state_d       = RESP;
        end else if (wdog_q != CNT_MAX) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= IDLE;
      PADDR         <= '0;
      PWDATA        <= '0;
      PWRITE        <= 1'b0;
      PSEL          <= 1'b0;
      PENABLE       <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      PADDR         <= paddr_d;
      PWDATA        <= pwdata_d;
      PWRITE        <= pwrite_d;
      PSEL          <= psel_d;
      PENABLE       <= penable_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_rdata_o   <= rsp_rdata_d;
      rsp_err_o     <= rsp_err_d;
      rsp_timeout_o <= rsp_timeout_d;
      wdog_q        <= wdog_d;
    end
  end

`ifndef SYNTHESIS
  a_penable_needs_psel: assert property (@(posedge HCLK) disable iff (!HRESETn)
    PENABLE |-> PSEL);
  a_setup_to_access: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (PSEL && !PENABLE) |=> (PSEL && PENABLE));
  a_access_stable: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (PSEL && PENABLE && !PREADY) |=> ($stable(PADDR) && $stable(PWDATA) && $stable(PWRITE)));
  a_rsp_hold: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (rsp_valid_o && !rsp_ready_i) |=>
      (rsp_valid_o && $stable(rsp_rdata_o) && $stable(rsp_err_o) && $stable(rsp_timeout_o)));
`endif

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master: zero-wait, wait-state, slave-error, watchdog,
// back-pressure/back-to-back and mid-transfer reset scenarios.
module tb_apb_req_master;

  localparam logic [11:0] B_ADDR  = 12'h0C4;
  localparam logic [31:0] B_WDATA = 32'hCAFE_0001;

  logic        HCLK;
  logic        HRESETn;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_write_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  apb_req_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_write_i(req_write_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE, act as the APB slave (waits wait states, then PREADY),
  // check latency/protocol/response, optionally back-pressure for bp cycles while a
  // second request (B_ADDR/B_WDATA) is queued, then complete the response handshake.
  task automatic xfer(input string pfx, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic wr, input int waits, input logic [31:0] prdata,
                      input logic slverr, input logic [31:0] exp_rdata, input logic exp_err,
                      input logic exp_to, input int exp_lat, input int bp, input bit queue_b);
    int lat;
    int acc;
    logic stable_ok, proto_ok, hold_ok;
    logic [31:0] r0;
    logic e0, t0;
    check({pfx, "_req_ready"}, req_ready_o, 1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_write_i = wr;
    @(negedge HCLK);
    req_valid_i = 1'b0;
    lat = 1;
    acc = 0;
    stable_ok = 1'b1;
    proto_ok  = 1'b1;
    while (rsp_valid_o !== 1'b1 && lat < 40) begin
      if (PSEL !== 1'b1 || PADDR !== addr || PWDATA !== wdata || PWRITE !== wr) stable_ok = 1'b0;
      if (lat == 1 && PENABLE !== 1'b0) proto_ok = 1'b0;
      if (lat >= 2 && PENABLE !== 1'b1) proto_ok = 1'b0;
      if (req_ready_o !== 1'b0) proto_ok = 1'b0;
      if (PSEL && PENABLE) begin
        PREADY = (acc >= waits);
        acc++;
      end else begin
        PREADY = (waits == 0);
      end
      PSLVERR = PREADY ? slverr : 1'b0;
      PRDATA  = PREADY ? prdata : (32'hBAD0_0000 | acc);
      @(negedge HCLK);
      lat++;
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    check({pfx, "_rsp_valid"}, rsp_valid_o, 1);
    check({pfx, "_latency"}, lat, exp_lat);
    check({pfx, "_apb_stable"}, stable_ok, 1);
    check({pfx, "_apb_proto"}, proto_ok, 1);
    check({pfx, "_rdata"}, rsp_rdata_o, exp_rdata);
    check({pfx, "_err"}, rsp_err_o, exp_err);
    check({pfx, "_timeout"}, rsp_timeout_o, exp_to);
    check({pfx, "_psel_drop"}, {PSEL, PENABLE}, 2'b00);
    r0 = rsp_rdata_o;
    e0 = rsp_err_o;
    t0 = rsp_timeout_o;
    if (bp > 0) begin
      if (queue_b) begin
        req_valid_i = 1'b1;
        req_addr_i  = B_ADDR;
        req_wdata_i = B_WDATA;
        req_write_i = 1'b1;
      end
      hold_ok = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(negedge HCLK);
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== r0 || rsp_err_o !== e0 ||
            rsp_timeout_o !== t0 || req_ready_o !== 1'b0 || PSEL !== 1'b0 || PADDR !== addr)
          hold_ok = 1'b0;
      end
      check({pfx, "_bp_hold"}, hold_ok, 1);
    end
    rsp_ready_i = 1'b1;
    @(negedge HCLK);
    rsp_ready_i = 1'b0;
    check({pfx, "_rsp_done"}, rsp_valid_o, 0);
    check({pfx, "_idle_gap"}, {PSEL, req_ready_o, dbg_state}, {1'b0, 1'b1, 2'd0});
  endtask

  initial begin
    logic no_stale;
    HRESETn     = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_write_i = 1'b0;
    rsp_ready_i = 1'b0;
    PRDATA      = '0;
    PREADY      = 1'b0;
    PSLVERR     = 1'b0;
    repeat (2) @(negedge HCLK);

    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_err", {rsp_err_o, rsp_timeout_o}, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_state", dbg_state, 0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // zero-wait write, PRDATA driven non-zero so a write must still return rdata 0
    xfer("wr0", 12'h008, 32'h0000_0010, 1'b1, 0, 32'hFFFF_FFFF, 1'b0,
         32'h0, 1'b0, 1'b0, 3, 0, 1'b0);
    // three wait states: PREADY lands on the fourth ACCESS cycle, just ahead of the watchdog
    xfer("rd3", 12'h000, 32'h0, 1'b0, 3, 32'hDEAD_BEEF, 1'b0,
         32'hDEAD_BEEF, 1'b0, 1'b0, 6, 0, 1'b0);
    xfer("slverr", 12'h004, 32'h0, 1'b0, 0, 32'h0000_1234, 1'b1,
         32'h0, 1'b1, 1'b0, 3, 0, 1'b0);
    xfer("tmo", 12'h010, 32'h0, 1'b0, 100, 32'h5555_5555, 1'b0,
         32'h0, 1'b1, 1'b1, 6, 0, 1'b0);
    xfer("bp", 12'h020, 32'hA5A5_0F0F, 1'b1, 1, 32'h0, 1'b0,
         32'h0, 1'b0, 1'b0, 4, 5, 1'b1);
    xfer("b2b", B_ADDR, B_WDATA, 1'b1, 0, 32'h0, 1'b0,
         32'h0, 1'b0, 1'b0, 3, 0, 1'b0);

    // reset in the middle of an ACCESS wait state
    req_valid_i = 1'b1;
    req_addr_i  = 12'h030;
    req_wdata_i = 32'h0;
    req_write_i = 1'b0;
    @(negedge HCLK);
    req_valid_i = 1'b0;
    repeat (2) @(negedge HCLK);
    check("mid_in_access", {dbg_state, PSEL, PENABLE}, {2'd2, 1'b1, 1'b1});
    #2 HRESETn = 1'b0;
    #1;
    check("mid_rst_apb", {PSEL, PENABLE}, 2'b00);
    check("mid_rst_rsp", rsp_valid_o, 0);
    check("mid_rst_ready", req_ready_o, 1);
    repeat (2) @(negedge HCLK);
    HRESETn  = 1'b1;
    PREADY   = 1'b1;
    no_stale = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      if (rsp_valid_o !== 1'b0 || PSEL !== 1'b0 || req_ready_o !== 1'b1 || dbg_state !== 2'd0)
        no_stale = 1'b0;
    end
    PREADY = 1'b0;
    check("post_rst_no_stale", no_stale, 1);

    xfer("recov", 12'h0FC, 32'h0, 1'b0, 1, 32'h0BAD_F00D, 1'b0,
         32'h0BAD_F00D, 1'b0, 1'b0, 4, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_req_master.md
Name: apb_req_master

Overview:
- APB initiator: converts a single-outstanding valid/ready request channel into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response channel.
- Sits between a core-side bus adapter and APB peripherals, for example the timer (PREADY and PSLVERR tied 1/0) or slaves that insert wait states.
- Adds a watchdog so a hung slave cannot stall the initiator.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR and req_addr_i.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles allowed with PREADY low before abort. 0 disables the watchdog.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  APB_ADDR_WIDTH  transfer address
- req_wdata_i  in  32  write data
- req_write_i  in  1  1=write, 0=read
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  32  read data (0 for writes/errors)
- rsp_err_o  out  1  PSLVERR seen or timeout
- rsp_timeout_o  out  1  transfer aborted by watchdog
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset and clock: reset HRESETn, asynchronous, active-low; clock HCLK.
- Reset values:
  - state=IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid_o, rsp_err_o and rsp_timeout_o are 0.
  - PADDR, PWDATA and rsp_rdata_o are 0.
  - Watchdog counter is 0.
- All APB outputs and rsp_* are registered. None depend combinationally on inputs.
- req_ready_o = (state==IDLE). It is combinational from state only.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On req_valid_i, latch addr, wdata and write into PADDR, PWDATA and PWRITE, set PSEL=1, and go to SETUP.
  - PADDR, PWDATA and PWRITE otherwise hold their last values.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0. Set PENABLE=1 and go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWDATA and PWRITE are stable.
  - PREADY=1:
    - Capture rsp_rdata_o = PWRITE ? 0 : PRDATA.
    - rsp_err_o = PSLVERR and rsp_timeout_o = 0.
    - If PSLVERR=1 on a read, rdata is forced to 0.
    - Drop PSEL and PENABLE, set rsp_valid_o=1, clear the counter, go to RESP.
  - PREADY=0 and (TIMEOUT_CYCLES==0 or counter < TIMEOUT_CYCLES-1): counter += 1, stay in ACCESS.
  - PREADY=0 and counter == TIMEOUT_CYCLES-1 (abort):
    - Drop PSEL and PENABLE.
    - rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
    - rsp_valid_o=1, clear the counter, go to RESP.
- PREADY wins over timeout in the same cycle.
- Watchdog counter width is clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- RESP: hold rsp_* stable while rsp_ready_i=0. On rsp_ready_i=1, rsp_valid_o is 0 next cycle and state goes to IDLE.
  - A new request may be accepted in the IDLE cycle that follows.
  - There is no IDLE bypass, so transfers are always separated by ≥1 IDLE cycle with PSEL=0.
- Latency: request accepted at cycle N → SETUP N+1 → ACCESS N+2 → rsp_valid_o at N+3 + wait states.
- Single outstanding transfer. Request inputs are ignored outside IDLE.
- Reset mid-transfer:
  - All outputs return to reset values immediately (async).
  - No response is produced for the aborted transfer.
- PSEL never deasserts between SETUP and ACCESS of one transfer.
- PENABLE is never 1 while PSEL=0.

Test Plan:
- Zero-wait write: req addr=0x008, wdata=0x0000_0010, write=1; slave PREADY=1 → PSEL rises N+1, PENABLE N+2, rsp_valid N+3, err=0, rdata=0; PWDATA=0x10 during SETUP+ACCESS.
- Read with 3 wait states: addr=0x000; PREADY low 3 ACCESS cycles then high with PRDATA=0xDEAD_BEEF → rsp_valid at N+6, rdata=0xDEADBEEF, err=0; PADDR stable throughout.
- Slave error: read with PREADY=1, PSLVERR=1, PRDATA=0x1234 → rsp_err=1, rsp_timeout=0, rdata=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0 → PSEL and PENABLE drop after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rdata=0. Then a PREADY=1 on cycle 4 (counter==3) completes normally.
- Back-pressure and back-to-back: rsp_ready_i low for 5 cycles → rsp fields stable, req_ready_o=0. Second request queued on req_valid_i is accepted only after the handshake, with one PSEL=0 cycle between transfers.
- Reset mid-ACCESS: assert HRESETn=0 during a wait state → PSEL, PENABLE and rsp_valid 0 immediately. After release, state is IDLE, req_ready_o=1, and no stale response appears.
